// File: rtl/instr_sequencer.sv
// Eight-phase instruction-cycle controller for the VeriRISC CPU: phase counter, halt state, datapath strobes.
// Optional build macro INSTR_SEQ_RESUME_EN adds a resume input that restarts a halted sequencer at phase 0.
//
// state | meaning
// ------+-------------------------------------------------------
// 0     | INST_ADDR  - PC drives memory address
// 1     | INST_FETCH - read instruction word
// 2     | INST_LOAD  - load IR
// 3     | IDLE       - IR stable, hold read
// 4     | OP_ADDR    - bump PC, detect HLT
// 5     | OP_FETCH   - operand read for ALU ops
// 6     | ALU_OP     - SKZ skip, JMP load, STO drive bus
// 7     | STORE      - accumulator load / memory write / JMP load
// halted| phase frozen at 4, only halt asserted

module instr_sequencer #(
    parameter int OP_WIDTH = 3,
    parameter int PHASES   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enab,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic                zero,
`ifdef INSTR_SEQ_RESUME_EN
    input  logic                resume,
`endif
    output logic [2:0]          phase,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                halt,
    output logic                inc_pc,
    output logic                ld_pc,
    output logic                ld_ac,
    output logic                data_e,
    output logic                wr
);

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;
    localparam logic [2:0] PH_LAST       = 3'(PHASES - 1);

    localparam logic [OP_WIDTH-1:0] OP_HLT = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_SKZ = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_ADD = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_LDA = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_STO = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_JMP = OP_WIDTH'(7);

    logic [2:0] phase_nxt;
    logic       halted;
    logic       halted_nxt;

    logic is_hlt;
    logic is_skz;
    logic is_jmp;
    logic is_sto;
    logic is_aluop;

    logic dec_sel;
    logic dec_rd;
    logic dec_ld_ir;
    logic dec_halt;
    logic dec_inc_pc;
    logic dec_ld_pc;
    logic dec_ld_ac;
    logic dec_data_e;
    logic dec_wr;

    logic strobe_ok;

    assign is_hlt   = (opcode == OP_HLT);
    assign is_skz   = (opcode == OP_SKZ);
    assign is_jmp   = (opcode == OP_JMP);
    assign is_sto   = (opcode == OP_STO);
    assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                      (opcode == OP_XOR) || (opcode == OP_LDA);

    // Halting freezes the phase at OP_ADDR rather than advancing; only resume or reset leaves it.
    always_comb begin
        phase_nxt  = phase;
        halted_nxt = halted;
        if (enab) begin
            if (halted) begin
`ifdef INSTR_SEQ_RESUME_EN
                if (resume) begin
                    halted_nxt = 1'b0;
                    phase_nxt  = PH_INST_ADDR;
                end
`endif
            end else if ((phase == PH_OP_ADDR) && is_hlt) begin
                halted_nxt = 1'b1;
            end else if (phase == PH_LAST) begin
                phase_nxt = PH_INST_ADDR;
            end else begin
                phase_nxt = phase + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= PH_INST_ADDR;
            halted <= 1'b0;
        end else begin
            phase  <= phase_nxt;
            halted <= halted_nxt;
        end
    end

    always_comb begin
        dec_sel    = 1'b0;
        dec_rd     = 1'b0;
        dec_ld_ir  = 1'b0;
        dec_halt   = 1'b0;
        dec_inc_pc = 1'b0;
        dec_ld_pc  = 1'b0;
        dec_ld_ac  = 1'b0;
        dec_data_e = 1'b0;
        dec_wr     = 1'b0;
        case (phase)
            PH_INST_ADDR: begin
                dec_sel = 1'b1;
            end
            PH_INST_FETCH: begin
                dec_sel = 1'b1;
                dec_rd  = 1'b1;
            end
            PH_INST_LOAD, PH_IDLE: begin
                dec_sel   = 1'b1;
                dec_rd    = 1'b1;
                dec_ld_ir = 1'b1;
            end
            PH_OP_ADDR: begin
                dec_inc_pc = 1'b1;
                dec_halt   = is_hlt;
            end
            PH_OP_FETCH: begin
                dec_rd = is_aluop;
            end
            PH_ALU_OP: begin
                dec_rd     = is_aluop;
                dec_inc_pc = is_skz && zero;
                dec_ld_pc  = is_jmp;
                dec_data_e = is_sto;
            end
            PH_STORE: begin
                dec_rd     = is_aluop;
                dec_ld_ac  = is_aluop;
                dec_inc_pc = is_jmp;
                dec_ld_pc  = is_jmp;
                dec_wr     = is_sto;
                dec_data_e = is_sto;
            end
            default: begin
                dec_sel = 1'b0;
            end
        endcase
    end

    // Strobes fire only on cycles that actually advance; levels follow the decode during a stall.
    assign strobe_ok = enab && !halted;

    assign sel    = dec_sel    && !halted;
    assign rd     = dec_rd     && !halted;
    assign data_e = dec_data_e && !halted;
    assign halt   = dec_halt   || halted;

    assign ld_ir  = dec_ld_ir  && strobe_ok;
    assign inc_pc = dec_inc_pc && strobe_ok;
    assign ld_pc  = dec_ld_pc  && strobe_ok;
    assign ld_ac  = dec_ld_ac  && strobe_ok;
    assign wr     = dec_wr     && strobe_ok;

endmodule
